// File: rtl/c64_bus_arbiter.sv
// Shared-bus arbiter between the 6510 and VIC-II: phase enables, per-half address mux, RDY/grace.
// Define ARB_STALL_COUNT_EN to add o_stall_cnt (saturating count of ph2 cycles without CPU grant).
module c64_bus_arbiter #(
    parameter int P_CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_clk_8mhz_en,
    output logic        o_ph1_en,
    output logic        o_ph2_en,
    input  logic        i_vic_ba,
    input  logic        i_vic_bm,
    input  logic [15:0] i_vic_addr_ph1,
    input  logic [15:0] i_vic_addr_ph2,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_we,
    output logic        o_cpu_rdy,
    output logic        o_cpu_grant,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic        o_conflict
`ifdef ARB_STALL_COUNT_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);

    // state | meaning
    // RUN   | CPU owns every ph2, RDY high
    // GRACE | BA low; CPU writes still proceed, reads stall (at most 3 cycles)
    // HALT  | VIC owns ph2, CPU halted until BA and BM both release
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GRACE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int DW = (P_CLK_DIV > 2) ? $clog2(P_CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(P_CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    tick_q, tick_d;
    logic          tick_pulse, ph1_end, ph2_end;
    logic          clk8_q, ph1_en_q, ph2_en_q, in_ph2_q;

    state_t        state_q;
    logic [1:0]    grace_q, grace_inc;
    logic          rdy_q, grant_q, conflict_q;
    logic [15:0]   mem_addr_q;
    logic          mem_we_q;

    always_comb begin
        tick_pulse = (div_q == DIV_LAST);
        ph1_end    = tick_pulse && (tick_q == 3'd3);
        ph2_end    = tick_pulse && (tick_q == 3'd7);
        div_d      = tick_pulse ? '0 : div_q + DW'(1);
        tick_d     = tick_pulse ? tick_q + 3'd1 : tick_q;
        grace_inc  = grace_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            tick_q   <= '0;
            clk8_q   <= 1'b0;
            ph1_en_q <= 1'b0;
            ph2_en_q <= 1'b0;
            in_ph2_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            clk8_q   <= tick_pulse;
            ph1_en_q <= ph1_end;
            ph2_en_q <= ph2_end;
            // in_ph2 covers exactly the clocks where the latched grant applies
            if (ph1_en_q)
                in_ph2_q <= 1'b1;
            else if (ph2_end)
                in_ph2_q <= 1'b0;
        end
    end

    function automatic logic [16:0] ph2_bus(input logic g);
        ph2_bus = g ? {i_cpu_we, i_cpu_addr} : {1'b0, i_vic_addr_ph2};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            grace_q    <= 2'd0;
            rdy_q      <= 1'b1;
            grant_q    <= 1'b0;
            conflict_q <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_we_q   <= 1'b0;
        end else begin
            if (in_ph2_q && grant_q && !i_vic_bm)
                conflict_q <= 1'b1;

            if (ph2_en_q) begin
                mem_addr_q <= i_vic_addr_ph1;
                mem_we_q   <= 1'b0;
            end

            if (ph1_en_q) begin
                unique case (state_q)
                    ST_RUN: begin
                        if (!i_vic_bm) begin
                            state_q    <= ST_HALT;
                            rdy_q      <= 1'b0;
                            grant_q    <= 1'b0;
                            conflict_q <= 1'b1;
                            {mem_we_q, mem_addr_q} <= ph2_bus(1'b0);
                        end else if (!i_vic_ba) begin
                            state_q <= ST_GRACE;
                            grace_q <= 2'd0;
                            rdy_q   <= 1'b0;
                            grant_q <= i_cpu_we;
                            {mem_we_q, mem_addr_q} <= ph2_bus(i_cpu_we);
                        end else begin
                            rdy_q   <= 1'b1;
                            grant_q <= 1'b1;
                            {mem_we_q, mem_addr_q} <= ph2_bus(1'b1);
                        end
                    end
                    ST_GRACE: begin
                        if (i_vic_ba) begin
                            state_q <= ST_RUN;
                            rdy_q   <= 1'b1;
                            grant_q <= 1'b1;
                            {mem_we_q, mem_addr_q} <= ph2_bus(1'b1);
                        end else if (grace_inc == 2'd3 || !i_vic_bm) begin
                            state_q <= ST_HALT;
                            grace_q <= grace_inc;
                            grant_q <= 1'b0;
                            {mem_we_q, mem_addr_q} <= ph2_bus(1'b0);
                        end else begin
                            grace_q <= grace_inc;
                            grant_q <= i_cpu_we;
                            {mem_we_q, mem_addr_q} <= ph2_bus(i_cpu_we);
                        end
                    end
                    ST_HALT: begin
                        if (i_vic_ba && i_vic_bm) begin
                            state_q <= ST_RUN;
                            rdy_q   <= 1'b1;
                            grant_q <= 1'b1;
                            {mem_we_q, mem_addr_q} <= ph2_bus(1'b1);
                        end else begin
                            grant_q <= 1'b0;
                            {mem_we_q, mem_addr_q} <= ph2_bus(1'b0);
                        end
                    end
                    default: begin
                        state_q <= ST_HALT;
                        rdy_q   <= 1'b0;
                        grant_q <= 1'b0;
                        {mem_we_q, mem_addr_q} <= ph2_bus(1'b0);
                    end
                endcase
            end
        end
    end

`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= 16'h0000;
        else if (ph2_en_q && !grant_q && stall_cnt_q != 16'hffff)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

    assign o_clk_8mhz_en = clk8_q;
    assign o_ph1_en      = ph1_en_q;
    assign o_ph2_en      = ph2_en_q;
    assign o_cpu_rdy     = rdy_q;
    assign o_cpu_grant   = grant_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_we      = mem_we_q;
    assign o_conflict    = conflict_q;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Directed bench for c64_bus_arbiter: phase timing, address mux, grace/halt sequencing, conflict.
module tb_c64_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk8_en, ph1_en, ph2_en;
    logic        vic_ba = 1'b1, vic_bm = 1'b1;
    logic [15:0] vic_addr_ph1 = 16'h1111, vic_addr_ph2 = 16'h2222;
    logic [15:0] cpu_addr = 16'h0801;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy, cpu_grant, mem_we, conflict;
    logic [15:0] mem_addr;
`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c64_bus_arbiter #(.P_CLK_DIV(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_clk_8mhz_en (clk8_en),
        .o_ph1_en      (ph1_en),
        .o_ph2_en      (ph2_en),
        .i_vic_ba      (vic_ba),
        .i_vic_bm      (vic_bm),
        .i_vic_addr_ph1(vic_addr_ph1),
        .i_vic_addr_ph2(vic_addr_ph2),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_we      (cpu_we),
        .o_cpu_rdy     (cpu_rdy),
        .o_cpu_grant   (cpu_grant),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_conflict    (conflict)
`ifdef ARB_STALL_COUNT_EN
        ,
        .o_stall_cnt   (stall_cnt)
`endif
    );

    task automatic wait_ph1();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (ph1_en) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_ph1: o_ph1_en not seen within 100 clks (got 0, want 1)");
        end
    endtask

    task automatic wait_ph2();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (ph2_en) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_ph2: o_ph2_en not seen within 100 clks (got 0, want 1)");
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_addr;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({clk8_en, ph1_en, ph2_en, cpu_rdy, cpu_grant, mem_we, conflict, mem_addr} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got en=%b%b%b rdy=%b gnt=%b we=%b cf=%b addr=%h, want 000 1 0 0 0 0000",
                     clk8_en, ph1_en, ph2_en, cpu_rdy, cpu_grant, mem_we, conflict, mem_addr);
        end
`ifdef ARB_STALL_COUNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        rst = 1'b0;
        // k = number of rising edges since reset release; run in RUN with BA/BM high
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            checks++;
            if (clk8_en !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL clk8_timing k=%0d: got %b want %b", k, clk8_en, (k % 4) == 0);
            end
            checks++;
            if (ph1_en !== ((k % 32) == 16)) begin
                errors++;
                $display("FAIL ph1_timing k=%0d: got %b want %b", k, ph1_en, (k % 32) == 16);
            end
            checks++;
            if (ph2_en !== ((k % 32) == 0)) begin
                errors++;
                $display("FAIL ph2_timing k=%0d: got %b want %b", k, ph2_en, (k % 32) == 0);
            end
            checks++;
            if (cpu_rdy !== 1'b1 || cpu_grant !== (k >= 17)) begin
                errors++;
                $display("FAIL run_rdy_grant k=%0d: got rdy=%b gnt=%b want rdy=1 gnt=%b",
                         k, cpu_rdy, cpu_grant, k >= 17);
            end
            if (k < 17) exp_addr = 16'h0000;
            else if (((k - 17) % 32) < 16) exp_addr = 16'h0801;
            else exp_addr = 16'h1111;
            checks++;
            if (mem_addr !== exp_addr || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL run_bus k=%0d: got addr=%h we=%b want addr=%h we=0",
                         k, mem_addr, mem_we, exp_addr);
            end
        end
    endtask

    task automatic test_ba_read();
        wait_ph2();
        vic_ba = 1'b0;
        cpu_we = 1'b0;
        wait_ph1();
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ba_read_pre: rdy got %b want 1", cpu_rdy);
        end
        @(negedge clk);
        checks++;
        if (cpu_rdy !== 1'b0 || cpu_grant !== 1'b0 || mem_addr !== 16'h2222 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL ba_read_stall: got rdy=%b gnt=%b addr=%h we=%b want rdy=0 gnt=0 addr=2222 we=0",
                     cpu_rdy, cpu_grant, mem_addr, mem_we);
        end
        wait_ph2();
        vic_ba = 1'b1;
        wait_ph1();
        @(negedge clk);
        checks++;
        if (cpu_rdy !== 1'b1 || cpu_grant !== 1'b1 || mem_addr !== 16'h0801) begin
            errors++;
            $display("FAIL ba_read_release: got rdy=%b gnt=%b addr=%h want rdy=1 gnt=1 addr=0801",
                     cpu_rdy, cpu_grant, mem_addr);
        end
    endtask

    task automatic test_grace_writes();
        wait_ph2();
        for (int i = 0; i < 4; i++) begin
            vic_ba   = 1'b0;
            vic_bm   = (i == 3) ? 1'b0 : 1'b1;
            cpu_we   = 1'b1;
            cpu_addr = 16'hc000 + 16'(i);
            wait_ph1();
            @(negedge clk);
            checks++;
            if (i < 3) begin
                if (cpu_grant !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'hc000 + 16'(i) || cpu_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL grace_write%0d: got gnt=%b we=%b addr=%h rdy=%b want gnt=1 we=1 addr=%h rdy=0",
                             i, cpu_grant, mem_we, mem_addr, cpu_rdy, 16'hc000 + 16'(i));
                end
            end else begin
                if (cpu_grant !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h2222) begin
                    errors++;
                    $display("FAIL grace_vic_owned: got gnt=%b we=%b addr=%h want gnt=0 we=0 addr=2222",
                             cpu_grant, mem_we, mem_addr);
                end
            end
            wait_ph2();
        end
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL grace_conflict: got %b want 0", conflict);
        end
        vic_ba   = 1'b1;
        vic_bm   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0801;
        wait_ph1();
        @(negedge clk);
        checks++;
        if (cpu_rdy !== 1'b1 || cpu_grant !== 1'b1 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL grace_release: got rdy=%b gnt=%b cf=%b want 1 1 0", cpu_rdy, cpu_grant, conflict);
        end
    endtask

    task automatic test_bm_conflict();
        wait_ph2();
        vic_bm = 1'b0;
        wait_ph1();
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL bm_conflict_pre: got %b want 0", conflict);
        end
        @(negedge clk);
        checks++;
        if (conflict !== 1'b1 || cpu_grant !== 1'b0 || cpu_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bm_conflict_set: got cf=%b gnt=%b rdy=%b want cf=1 gnt=0 rdy=0",
                     conflict, cpu_grant, cpu_rdy);
        end
        wait_ph2();
        vic_bm = 1'b1;
        wait_ph1();
        @(negedge clk);
        checks++;
        if (cpu_rdy !== 1'b1 || conflict !== 1'b1) begin
            errors++;
            $display("FAIL bm_conflict_release: got rdy=%b cf=%b want rdy=1 cf=1", cpu_rdy, conflict);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (conflict !== 1'b1) begin
            errors++;
            $display("FAIL bm_conflict_sticky: got %b want 1", conflict);
        end
    endtask

    task automatic test_bad_line();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL bad_line_reset_conflict: got %b want 0", conflict);
        end
        wait_ph1();
        wait_ph2();
        cpu_we = 1'b0;
        // n=0..2 grace (read stalls), n=3..42 halted with BM low, n=43 release
        for (int n = 0; n <= 43; n++) begin
            vic_ba = (n < 43) ? 1'b0 : 1'b1;
            vic_bm = (n >= 3 && n < 43) ? 1'b0 : 1'b1;
            wait_ph1();
            @(negedge clk);
            if (n == 0 || n == 3 || n == 42) begin
                checks++;
                if (cpu_rdy !== 1'b0 || cpu_grant !== 1'b0 || mem_addr !== 16'h2222) begin
                    errors++;
                    $display("FAIL bad_line_stall n=%0d: got rdy=%b gnt=%b addr=%h want rdy=0 gnt=0 addr=2222",
                             n, cpu_rdy, cpu_grant, mem_addr);
                end
            end
            if (n == 43) begin
                checks++;
                if (cpu_rdy !== 1'b1 || cpu_grant !== 1'b1 || mem_addr !== 16'h0801) begin
                    errors++;
                    $display("FAIL bad_line_release: got rdy=%b gnt=%b addr=%h want rdy=1 gnt=1 addr=0801",
                             cpu_rdy, cpu_grant, mem_addr);
                end
            end
            wait_ph2();
        end
        @(negedge clk);
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL bad_line_conflict: got %b want 0", conflict);
        end
`ifdef ARB_STALL_COUNT_EN
        checks++;
        if (stall_cnt !== 16'd43) begin
            errors++;
            $display("FAIL bad_line_stall_cnt: got %0d want 43", stall_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ba_read();
        test_grace_writes();
        test_bm_conflict();
        test_bad_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

endmodule
